// File: rtl/dht11_report_scheduler.sv
// DHT11 read sequencer: triggers reads, formats an ASCII frame, feeds the UART TX.
// Optional RX command decoding ('S' trigger, 'A' auto toggle) under `define RX_CMD_EN.
module dht11_report_scheduler #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int PERIOD_MS  = 2000,
    parameter int TIMEOUT_MS = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       auto_en,
    output logic       dht_start,
    input  logic       dht_done,
    input  logic       dht_err,
    input  logic [7:0] rh_data,
    input  logic [7:0] t_data,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_busy,
    input  logic       tx_done,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    output logic       busy,
    output logic       frame_done,
    output logic [7:0] err_cnt,
    output logic [7:0] last_rh,
    output logic [7:0] last_t
);

    localparam int DIV = (CLK_HZ / 1000 < 1) ? 1 : CLK_HZ / 1000;
    localparam int PW  = $clog2(DIV + 1);
    localparam int QW  = $clog2(PERIOD_MS + 1);
    localparam int TW  = $clog2(TIMEOUT_MS + 1);
    localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
    localparam logic [QW-1:0] PER_MAX = QW'(PERIOD_MS - 1);
    localparam logic [TW-1:0] TMO     = TW'(TIMEOUT_MS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT_DHT,
        S_SEND,
        S_WAIT_TX
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [QW-1:0] per_q, per_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          pending_q, pending_d;
    logic [3:0]    idx_q, idx_d;
    logic          ok_q, ok_d;
    logic [7:0]    err_q, err_d;
    logic [7:0]    rh_q, rh_d;
    logic [7:0]    t_q, t_d;
    logic [7:0]    txd_q, txd_d;
    logic          txs_q, txs_d;
    logic          fd_q, fd_d;

    logic          tick;
    logic          wrap;
    logic          take;
    logic          auto_bit;
    logic          rx_req;
    logic [15:0]   rh_asc;
    logic [15:0]   t_asc;
    logic [7:0]    byte_sel;
    logic [3:0]    last_idx;

`ifdef RX_CMD_EN
    logic auto_bit_q;

    assign rx_req   = rx_done && (rx_data == 8'h53);
    assign auto_bit = auto_bit_q;

    // Host 'A' command flips the internal periodic enable
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            auto_bit_q <= 1'b1;
        end else if (rx_done && (rx_data == 8'h41)) begin
            auto_bit_q <= ~auto_bit_q;
        end
    end
`else
    logic unused_rx;

    assign unused_rx = ^{rx_data, rx_done};
    assign rx_req    = 1'b0;
    assign auto_bit  = 1'b1;
`endif

    // Two-digit ASCII of a value clamped to 99
    function automatic logic [15:0] to_ascii(input logic [7:0] v);
        logic [7:0] c;
        logic [7:0] tens;
        logic [7:0] ones;
        c    = (v > 8'd99) ? 8'd99 : v;
        tens = c / 8'd10;
        ones = c - tens * 8'd10;
        return {8'h30 + tens, 8'h30 + ones};
    endfunction

    assign tick = (presc_q == PRE_MAX);
    assign wrap = tick && (per_q == PER_MAX);
    assign take = (state_q == S_IDLE) && pending_q;

    assign presc_d   = tick ? '0 : presc_q + 1'b1;
    assign per_d     = !tick ? per_q : (wrap ? '0 : per_q + 1'b1);
    assign pending_d = (pending_q && !take) || btn_start || rx_req
                       || (wrap && auto_en && auto_bit);

    // Free-running ms timebase and the single-entry request flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q   <= '0;
            per_q     <= '0;
            pending_q <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            per_q     <= per_d;
            pending_q <= pending_d;
        end
    end

    assign rh_asc   = to_ascii(rh_q);
    assign t_asc    = to_ascii(t_q);
    assign last_idx = ok_q ? 4'd8 : 4'd4;

    // Current frame byte selected by idx
    always_comb begin
        byte_sel = 8'h0A;
        if (ok_q) begin
            case (idx_q)
                4'd0:    byte_sel = 8'h48;
                4'd1:    byte_sel = rh_asc[15:8];
                4'd2:    byte_sel = rh_asc[7:0];
                4'd3:    byte_sel = 8'h20;
                4'd4:    byte_sel = 8'h54;
                4'd5:    byte_sel = t_asc[15:8];
                4'd6:    byte_sel = t_asc[7:0];
                4'd7:    byte_sel = 8'h0D;
                default: byte_sel = 8'h0A;
            endcase
        end else begin
            case (idx_q)
                4'd0:    byte_sel = 8'h45;
                4'd1:    byte_sel = 8'h52;
                4'd2:    byte_sel = 8'h52;
                4'd3:    byte_sel = 8'h0D;
                default: byte_sel = 8'h0A;
            endcase
        end
    end

    // Sequencer next-state and registered pulse outputs
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tmo_d   = tmo_q;
        ok_d    = ok_q;
        err_d   = err_q;
        rh_d    = rh_q;
        t_d     = t_q;
        txd_d   = txd_q;
        txs_d   = 1'b0;
        fd_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pending_q) state_d = S_TRIG;
            end
            S_TRIG: begin
                tmo_d   = '0;
                idx_d   = '0;
                state_d = S_WAIT_DHT;
            end
            S_WAIT_DHT: begin
                if (tick && (tmo_q != TMO)) tmo_d = tmo_q + 1'b1;
                if (dht_done) begin
                    rh_d    = rh_data;
                    t_d     = t_data;
                    ok_d    = 1'b1;
                    state_d = S_SEND;
                end else if (dht_err || (tmo_q == TMO)) begin
                    if (err_q != 8'hFF) err_d = err_q + 8'd1;
                    ok_d    = 1'b0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (!tx_busy) begin
                    txs_d   = 1'b1;
                    txd_d   = byte_sel;
                    state_d = S_WAIT_TX;
                end
            end
            S_WAIT_TX: begin
                if (tx_done) begin
                    if (idx_q == last_idx) begin
                        fd_d    = 1'b1;
                        idx_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = S_SEND;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sequencer state register; reset aborts any frame in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            tmo_q   <= '0;
            ok_q    <= 1'b0;
            err_q   <= '0;
            rh_q    <= '0;
            t_q     <= '0;
            txd_q   <= '0;
            txs_q   <= 1'b0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tmo_q   <= tmo_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
            rh_q    <= rh_d;
            t_q     <= t_d;
            txd_q   <= txd_d;
            txs_q   <= txs_d;
            fd_q    <= fd_d;
        end
    end

    assign dht_start  = (state_q == S_TRIG);
    assign busy       = (state_q != S_IDLE);
    assign tx_start   = txs_q;
    assign tx_data    = txd_q;
    assign frame_done = fd_q;
    assign err_cnt    = err_q;
    assign last_rh    = rh_q;
    assign last_t     = t_q;

endmodule

// File: tb/tb_dht11_report_scheduler.sv
// Directed bench for dht11_report_scheduler with DHT11 and UART TX models.
// Frame bytes are hand-computed ASCII vectors.
module tb_dht11_report_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_start = 1'b0;
    logic       auto_en = 1'b0;
    logic       dht_start;
    logic       dht_done = 1'b0;
    logic       dht_err = 1'b0;
    logic [7:0] rh_data = 8'h00;
    logic [7:0] t_data = 8'h00;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy = 1'b0;
    logic       tx_done = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done = 1'b0;
    logic       busy;
    logic       frame_done;
    logic [7:0] err_cnt;
    logic [7:0] last_rh;
    logic [7:0] last_t;

    int total = 0;
    int bad = 0;
    int fd_cnt = 0;
    int st_cnt = 0;
    int viol = 0;
    int dmode = 1;
    int extra = 0;
    logic [7:0] m_rh = 8'd0;
    logic [7:0] m_t = 8'd0;
    logic [7:0] bytes[$];

    logic [7:0] f45 [9];
    logic [7:0] f61 [9];
    logic [7:0] f99 [9];
    logic [7:0] ferr [9];

    dht11_report_scheduler #(
        .CLK_HZ(1000),
        .PERIOD_MS(5),
        .TIMEOUT_MS(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_start(btn_start),
        .auto_en(auto_en),
        .dht_start(dht_start),
        .dht_done(dht_done),
        .dht_err(dht_err),
        .rh_data(rh_data),
        .t_data(t_data),
        .tx_start(tx_start),
        .tx_data(tx_data),
        .tx_busy(tx_busy),
        .tx_done(tx_done),
        .rx_data(rx_data),
        .rx_done(rx_done),
        .busy(busy),
        .frame_done(frame_done),
        .err_cnt(err_cnt),
        .last_rh(last_rh),
        .last_t(last_t)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic chk_frame(input string tag, input int base,
                             input logic [7:0] e [9], input int n);
        logic [7:0] g;
        for (int i = 0; i < n; i++) begin
            g = (base + i < bytes.size()) ? bytes[base + i] : 8'hxx;
            chk($sformatf("%s[%0d]", tag, i), {24'd0, g}, {24'd0, e[i]});
        end
    endtask

    task automatic pulse_btn();
        @(negedge clk);
        btn_start = 1'b1;
        @(negedge clk);
        btn_start = 1'b0;
    endtask

    task automatic wait_fd(input string tag, input int n, input int budget);
        for (int i = 0; i < budget && fd_cnt < n; i++) @(negedge clk);
        chk(tag, fd_cnt, n);
    endtask

    task automatic clear_log();
        @(negedge clk);
        bytes.delete();
        fd_cnt = 0;
        st_cnt = 0;
        viol = 0;
    endtask

    // Event counters and busy-rule monitor
    initial forever begin
        logic b;
        @(posedge clk);
        b = tx_busy;
        @(negedge clk);
        if (frame_done) fd_cnt++;
        if (dht_start) st_cnt++;
        if (tx_start && b) viol++;
    end

    // DHT11 controller model: mode 0 silent, 1 done, 2 done+err together
    initial forever begin
        @(negedge clk);
        if (dht_start && dmode != 0) begin
            @(negedge clk);
            rh_data = m_rh;
            t_data = m_t;
            dht_done = 1'b1;
            dht_err = (dmode == 2);
            @(negedge clk);
            dht_done = 1'b0;
            dht_err = 1'b0;
        end
    end

    // UART TX model: 3-cycle byte, optional busy tail after tx_done
    initial forever begin
        @(negedge clk);
        if (tx_start) begin
            bytes.push_back(tx_data);
            tx_busy = 1'b1;
            repeat (3) @(negedge clk);
            tx_done = 1'b1;
            if (extra == 0) tx_busy = 1'b0;
            @(negedge clk);
            tx_done = 1'b0;
            repeat (extra) @(negedge clk);
            tx_busy = 1'b0;
        end
    end

    initial begin
        f45 = '{8'h48, 8'h34, 8'h35, 8'h20, 8'h54, 8'h32, 8'h33, 8'h0D, 8'h0A};
        f61 = '{8'h48, 8'h36, 8'h31, 8'h20, 8'h54, 8'h33, 8'h38, 8'h0D, 8'h0A};
        f99 = '{8'h48, 8'h39, 8'h39, 8'h20, 8'h54, 8'h30, 8'h37, 8'h0D, 8'h0A};
        ferr = '{8'h45, 8'h52, 8'h52, 8'h0D, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_txs", tx_start, 0);
        chk("rst_dhts", dht_start, 0);
        chk("rst_err", err_cnt, 0);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_bytes", bytes.size(), 0);

        // Button-triggered OK frame
        clear_log();
        dmode = 1;
        m_rh = 8'd45;
        m_t = 8'd23;
        pulse_btn();
        wait_fd("ok_fd", 1, 500);
        repeat (30) @(negedge clk);
        chk("ok_starts", st_cnt, 1);
        chk("ok_fd_once", fd_cnt, 1);
        chk("ok_len", bytes.size(), 9);
        chk_frame("ok_b", 0, f45, 9);
        chk("ok_rh", last_rh, 45);
        chk("ok_t", last_t, 23);
        chk("ok_busy", busy, 0);

        // Silent sensor: timeout gives ERR frame
        clear_log();
        dmode = 0;
        pulse_btn();
        wait_fd("to_fd", 1, 500);
        repeat (30) @(negedge clk);
        chk("to_err", err_cnt, 1);
        chk("to_len", bytes.size(), 5);
        chk_frame("to_b", 0, ferr, 5);
        chk("to_rh", last_rh, 45);
        chk("to_t", last_t, 23);

        // Clamp to 99, done+err together counts as OK
        clear_log();
        dmode = 2;
        m_rh = 8'd120;
        m_t = 8'd7;
        pulse_btn();
        wait_fd("cl_fd", 1, 500);
        repeat (30) @(negedge clk);
        chk("cl_err", err_cnt, 1);
        chk("cl_len", bytes.size(), 9);
        chk_frame("cl_b", 0, f99, 9);
        chk("cl_rh", last_rh, 120);

        // Three presses while busy coalesce into one more frame
        clear_log();
        dmode = 1;
        m_rh = 8'd45;
        m_t = 8'd23;
        pulse_btn();
        for (int i = 0; i < 100 && st_cnt < 1; i++) @(negedge clk);
        repeat (3) begin
            pulse_btn();
            repeat (4) @(negedge clk);
        end
        wait_fd("co_fd", 2, 1000);
        repeat (60) @(negedge clk);
        chk("co_fd_n", fd_cnt, 2);
        chk("co_starts", st_cnt, 2);
        chk("co_len", bytes.size(), 18);
        chk_frame("co_b0", 0, f45, 9);
        chk_frame("co_b1", 9, f45, 9);

        // Periodic trigger with slow UART; wraps during a frame merge
        clear_log();
        extra = 10;
        m_rh = 8'd61;
        m_t = 8'd38;
        auto_en = 1'b1;
        for (int i = 0; i < 100 && st_cnt < 1; i++) @(negedge clk);
        repeat (12) @(negedge clk);
        auto_en = 1'b0;
        wait_fd("au_fd", 2, 2000);
        repeat (100) @(negedge clk);
        chk("au_fd_n", fd_cnt, 2);
        chk("au_starts", st_cnt, 2);
        chk("au_viol", viol, 0);
        chk("au_len", bytes.size(), 18);
        chk_frame("au_b0", 0, f61, 9);
        chk_frame("au_b1", 9, f61, 9);
        extra = 0;

        // Reset while the fourth byte is on the wire
        clear_log();
        m_rh = 8'd45;
        m_t = 8'd23;
        pulse_btn();
        for (int i = 0; i < 500 && bytes.size() < 4; i++) @(negedge clk);
        chk("mr_at4", bytes.size(), 4);
        rst = 1'b0;
        #1;
        chk("mr_busy", busy, 0);
        chk("mr_txs", tx_start, 0);
        chk("mr_txd", tx_data, 0);
        chk("mr_fd", frame_done, 0);
        chk("mr_err", err_cnt, 0);
        chk("mr_rh", last_rh, 0);
        chk("mr_t", last_t, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (60) @(negedge clk);
        chk("mr_quiet", bytes.size(), 4);
        chk("mr_nostart", st_cnt, 1);
        chk("mr_nofd", fd_cnt, 0);

`ifdef RX_CMD_EN
        // Host 'S' command starts a frame
        clear_log();
        @(negedge clk);
        rx_data = 8'h53;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        wait_fd("rx_fd", 1, 500);
        repeat (30) @(negedge clk);
        chk("rx_len", bytes.size(), 9);
        chk_frame("rx_b", 0, f45, 9);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dht11_report_scheduler.md
Name: dht11_report_scheduler

Overview:
Sequencer placed between the DHT11 measurement controller and the UART transmitter in the sensor sender design. It triggers DHT11 reads either periodically or on a button pulse, and waits for completion or timeout. It then formats the result as an ASCII frame and pushes it byte-by-byte into the UART TX. The UART link is never handed bytes while busy, and concurrent requests are coalesced.

Parameters:
CLK_HZ, 100_000_000, system clock frequency; one ms tick every CLK_HZ/1000 cycles
PERIOD_MS, 2000, auto-trigger interval in ms (≥2)
TIMEOUT_MS, 50, maximum wait for dht_done/dht_err after dht_start

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
btn_start  in  1  debounced single-cycle manual trigger
auto_en  in  1  1 = periodic triggering enabled
dht_start  out  1  one-cycle pulse to DHT11 controller
dht_done  in  1  one-cycle pulse: rh_data/t_data valid
dht_err  in  1  one-cycle pulse: checksum/protocol failure
rh_data  in  8  humidity integer part
t_data  in  8  temperature integer part
tx_start  out  1  one-cycle pulse: load tx_data into UART
tx_data  out  8  byte to transmit
tx_busy  in  1  UART transmitting
tx_done  in  1  one-cycle pulse at end of stop bit
rx_data  in  8  received UART byte (used only with RX_CMD_EN)
rx_done  in  1  rx_data valid pulse (used only with RX_CMD_EN)
busy  out  1  high in any state except IDLE
frame_done  out  1  one-cycle pulse after last byte's tx_done
err_cnt  out  8  saturating count of failed reads
last_rh  out  8  last good humidity
last_t  out  8  last good temperature

Behaviour:
- Reset: all outputs 0; state IDLE; ms prescaler, period counter and pending flag cleared.
- ms tick: prescaler wraps at CLK_HZ/1000-1. Period counter increments per tick and wraps at PERIOD_MS-1. The wrap sets pending when auto_en=1. The counter runs continuously even while busy.
- btn_start sets pending. Requests arriving while pending is already set, or arriving while busy, merge into one pending request; at most one queued request.
- FSM:
  - IDLE: when pending=1, clear pending and go to TRIG.
  - TRIG: dht_start=1 for exactly one cycle; clear timeout counter; go to WAIT_DHT.
  - WAIT_DHT: on dht_done, latch rh/t into last_rh/last_t, select frame OK, go to SEND. On dht_err, or timeout counter reaching TIMEOUT_MS ticks, increment err_cnt (saturate at 255), select frame ERR, go to SEND. If dht_done and dht_err arrive in the same cycle, dht_done wins.
  - SEND: when tx_busy=0, drive tx_data=frame[idx] and tx_start=1 for one cycle, then go to WAIT_TX. If tx_busy=1, hold with no pulse.
  - WAIT_TX: on tx_done, if idx is the last byte, pulse frame_done and go to IDLE with idx=0; otherwise idx+1 and go to SEND.
- Frame OK, 9 bytes: 'H', rh tens, rh ones, ' ', 'T', t tens, t ones, 0x0D, 0x0A. Digits are ASCII '0'+n. Values >99 clamp to "99".
- Frame ERR, 5 bytes: 'E','R','R',0x0D,0x0A. last_rh and last_t are unchanged.
- BCD conversion is combinational from the latched values. tx_data holds its value between bytes.
- dht_done/dht_err pulses outside WAIT_DHT are ignored.
- Asynchronous reset mid-frame aborts immediately. No partial-frame resume.

Optional Feature:
RX_CMD_EN
- Defined: on rx_done, rx_data 'S' (0x53) sets pending. 'A' (0x41) toggles an internal auto-enable bit, reset value 1. Periodic triggering uses auto_en AND the internal bit. Other bytes are ignored.
- Undefined: rx_data and rx_done are ignored; the internal bit is constant 1.

Test Plan:
- CLK_HZ=1000, PERIOD_MS=5, auto_en=0, btn_start pulse; model returns dht_done with rh=45, t=23 → exactly one dht_start, then bytes 48 34 35 20 54 32 33 0D 0A, frame_done once, last_rh=45, last_t=23.
- Model never responds, TIMEOUT_MS=3 → after 3 ms ticks, err_cnt=1, bytes 45 52 52 0D 0A, last_rh/last_t unchanged.
- auto_en=1, model holds tx_busy=1 for 10 extra cycles per byte → no tx_start while tx_busy=1; still 9 bytes in order. A period wrap during transmission yields exactly one further frame after IDLE.
- btn_start pulsed 3 times while busy → exactly one extra measurement afterwards.
- rh=120, t=7 → digit bytes "99" and "07"; dht_done and dht_err in the same cycle → OK frame, err_cnt unchanged.
- Reset asserted during byte 4 → all outputs 0 within the same cycle. After release with no triggers, no tx_start occurs. With RX_CMD_EN defined, rx 'S' starts a frame.
